// File: rtl/j_mac_seq.sv
//------------------------------------------------------------------------------
// j_mac_seq : signed 16x16 multiply-accumulate burst sequencer, 40-bit
//             accumulator, 16/32-bit saturated result.
// Optional feature macro: J_MAC_SEQ_SATFLAG_EN (adds sat_flag / sat_sticky)
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module j_mac_seq #(
    parameter int CNT_W = 8,
    parameter int ACC_W = 40
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CNT_W-1:0]    cmd_len,
    input  logic                cmd_satszp,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic signed [15:0]  op_a,
    input  logic signed [15:0]  op_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [31:0]         res_data,
    output logic                busy
`ifdef J_MAC_SEQ_SATFLAG_EN
    ,
    output logic                sat_flag,
    output logic                sat_sticky
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat32;
    logic [31:0]        r_prod;
    logic               r_prod_v;
    logic               r_cmd_ready;
    logic               r_op_ready;
    logic               r_res_valid;
    logic [31:0]        r_res_data;
    logic               r_busy;

    logic signed [31:0] w_prod;
    logic [31:0]        w_d;
    logic [7:0]         w_x;
    logic               w_over32;
    logic               w_under32;
    logic               w_over16;
    logic               w_under16;
    logic [31:0]        w_sat_data;

    assign w_prod = op_a * op_b;

    // Saturation looks only at the low 40 bits; the accumulator wraps silently.
    assign w_d       = r_acc[31:0];
    assign w_x       = r_acc[39:32];
    assign w_over32  = !w_x[7] && (w_d[31] || (w_x[6:0] != 7'h00));
    assign w_under32 =  w_x[7] && !(w_d[31] && (w_x[6:0] == 7'h7F));
    assign w_over16  = !w_d[31] && (w_d[30:15] != 16'h0000);
    assign w_under16 =  w_d[31] && (w_d[30:15] != 16'hFFFF);

    always_comb begin
        w_sat_data = w_d;
        if (r_sat32) begin
            if (w_over32)
                w_sat_data = 32'h7FFF_FFFF;
            else if (w_under32)
                w_sat_data = 32'h8000_0000;
        end else begin
            if (w_over16)
                w_sat_data = 32'h0000_7FFF;
            else if (w_under16)
                w_sat_data = 32'hFFFF_8000;
        end
    end

`ifdef J_MAC_SEQ_SATFLAG_EN
    logic w_clamp;
    logic r_sat_flag;
    logic r_sat_sticky;

    assign w_clamp = r_sat32 ? (w_over32 || w_under32) : (w_over16 || w_under16);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_sat_flag   <= 1'b0;
            r_sat_sticky <= 1'b0;
        end else if (r_state == ST_DRAIN && !r_prod_v) begin
            r_sat_flag   <= w_clamp;
            r_sat_sticky <= r_sat_sticky | w_clamp;
        end else if (r_state == ST_RESULT && res_ready) begin
            r_sat_flag   <= 1'b0;
        end
    end

    assign sat_flag   = r_sat_flag;
    assign sat_sticky = r_sat_sticky;
`endif

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat32     <= 1'b0;
            r_prod      <= '0;
            r_prod_v    <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_op_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            // Second pipeline stage: fold the registered product into the sum.
            r_prod_v <= 1'b0;
            if (r_prod_v)
                r_acc <= r_acc + {{(ACC_W-32){r_prod[31]}}, r_prod};

            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_acc       <= '0;
                        r_cnt       <= cmd_len;
                        r_sat32     <= cmd_satszp;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (cmd_len == c_cnt_zero) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state    <= ST_ACCUM;
                            r_op_ready <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (op_valid && r_op_ready) begin
                        r_prod   <= w_prod;
                        r_prod_v <= 1'b1;
                        r_cnt    <= r_cnt - c_cnt_one;
                        if (r_cnt == c_cnt_one) begin
                            r_state    <= ST_DRAIN;
                            r_op_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!r_prod_v) begin
                        r_state     <= ST_RESULT;
                        r_res_valid <= 1'b1;
                        r_res_data  <= w_sat_data;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign op_ready  = r_op_ready;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_j_mac_seq.sv
//------------------------------------------------------------------------------
// tb_j_mac_seq : randomized self-checking bench for j_mac_seq against an
//                arithmetic sum/clamp reference model.
// Revision     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_j_mac_seq;

    localparam int CNT_W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [CNT_W-1:0]   cmd_len;
    logic               cmd_satszp;
    logic               op_valid;
    logic               op_ready;
    logic signed [15:0] op_a;
    logic signed [15:0] op_b;
    logic               res_valid;
    logic               res_ready;
    logic [31:0]        res_data;
    logic               busy;
`ifdef J_MAC_SEQ_SATFLAG_EN
    logic               sat_flag;
    logic               sat_sticky;
    bit                 m_sticky = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [15:0] qa[$];
    logic signed [15:0] qb[$];

    j_mac_seq #(.CNT_W(CNT_W), .ACC_W(40)) dut (
        .sys_clk    (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .cmd_satszp (cmd_satszp),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy)
`ifdef J_MAC_SEQ_SATFLAG_EN
        ,
        .sat_flag   (sat_flag),
        .sat_sticky (sat_sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer sum, wrapped to a signed 40-bit value, then clamped.
    function automatic logic [31:0] model_result(input bit sat32, output bit clamp);
        longint sum = 0;
        longint w;
        longint lo;
        for (int i = 0; i < qa.size(); i++)
            sum += longint'(qa[i]) * longint'(qb[i]);
        w = sum & ((64'sd1 <<< 40) - 1);
        if (w >= (64'sd1 <<< 39)) w -= (64'sd1 <<< 40);
        clamp = 1'b0;
        if (sat32) begin
            if (w > 64'sd2147483647) begin clamp = 1'b1; return 32'h7FFF_FFFF; end
            if (w < -64'sd2147483648) begin clamp = 1'b1; return 32'h8000_0000; end
            return w[31:0];
        end
        lo = w & 64'hFFFF_FFFF;
        if (lo >= 64'sd2147483648) lo -= 64'sd4294967296;
        if (lo > 64'sd32767) begin clamp = 1'b1; return 32'h0000_7FFF; end
        if (lo < -64'sd32768) begin clamp = 1'b1; return 32'hFFFF_8000; end
        return lo[31:0];
    endfunction

    function automatic logic signed [15:0] rnd16();
        case ($urandom_range(0, 3))
            0:       return ($urandom_range(0, 1) == 0) ? 16'sh7FFF : 16'sh8000;
            1:       return 16'($signed($urandom_range(0, 20)) - 10);
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic push(input logic signed [15:0] a, input logic signed [15:0] b);
        qa.push_back(a);
        qb.push_back(b);
    endtask

    // Runs one burst using the pairs in qa/qb; len must equal qa.size().
    task automatic run_burst(input string tag, input bit sat32, input bit gaps, input int stall);
        int  len = qa.size();
        int  n;
        int  i;
        int  cyc;
        bit  took;
        bit  exp_clamp;
        logic [31:0] exp;

        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_len    = CNT_W'(len);
        cmd_satszp = sat32;
        op_valid   = 1'b1;              // must be ignored while idle
        op_a       = 16'sh7FFF;
        op_b       = 16'sh7FFF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        op_valid  = 1'b0;
        check({tag, "_busy"}, busy, 1);

        i = 0;
        cyc = 0;
        while (i < len && cyc < 3000) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                op_valid = 1'b0;
            end else begin
                op_valid = 1'b1;
                op_a     = qa[i];
                op_b     = qb[i];
            end
            cmd_valid = 1'($urandom_range(0, 1));   // ignored outside idle
            cmd_len   = CNT_W'($urandom);
            took      = op_valid && op_ready;
            @(posedge clk);
            @(negedge clk);
            if (took) i++;
            cyc++;
        end
        op_valid  = 1'b0;
        cmd_valid = 1'b0;
        check({tag, "_pairs_taken"}, 64'(i), 64'(len));

        n = 0;
        while (!res_valid && n < 20) begin @(posedge clk); @(negedge clk); n++; end
        check({tag, "_res_valid"}, res_valid, 1);
        if (len == 0)
            check({tag, "_zero_latency"}, 64'(n), 64'd1);

        exp = model_result(sat32, exp_clamp);
        check({tag, "_res_data"}, res_data, exp);
`ifdef J_MAC_SEQ_SATFLAG_EN
        m_sticky |= exp_clamp;
        check({tag, "_sat_flag"}, sat_flag, exp_clamp);
        check({tag, "_sat_sticky"}, sat_sticky, m_sticky);
`endif

        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_stall_data"}, res_data, exp);
            check({tag, "_stall_cmd_ready"}, cmd_ready, 0);
            check({tag, "_stall_valid"}, res_valid, 1);
        end

        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_done_valid"}, res_valid, 0);
        check({tag, "_done_cmd_ready"}, cmd_ready, 1);
        check({tag, "_done_busy"}, busy, 0);
        qa.delete();
        qb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_op_ready"},  op_ready,  0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"},  res_data,  0);
        check({tag, "_busy"},      busy,      0);
`ifdef J_MAC_SEQ_SATFLAG_EN
        check({tag, "_sat_flag"},   sat_flag,   0);
        check({tag, "_sat_sticky"}, sat_sticky, 0);
`endif
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_len    = '0;
        cmd_satszp = 1'b0;
        op_valid   = 1'b0;
        op_a       = '0;
        op_b       = '0;
        res_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("in_reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");

        push(16'sd2, 16'sd3); push(16'sd4, 16'sd5); push(-16'sd1, 16'sd6);
        run_burst("basic32", 1'b1, 1'b0, 0);

        push(16'sh7FFF, 16'sh7FFF); push(16'sh7FFF, 16'sh7FFF);
        run_burst("pos_sat32", 1'b1, 1'b0, 0);

        push(16'sh0100, 16'sh0100);
        run_burst("pos_sat16", 1'b0, 1'b0, 0);

        push(-16'sd256, 16'sd256);
        run_burst("neg_sat16", 1'b0, 1'b0, 0);

        run_burst("len0_32", 1'b1, 1'b0, 0);
        run_burst("len0_16", 1'b0, 1'b0, 0);

        push(16'sd2, 16'sd3); push(16'sd4, 16'sd5); push(-16'sd1, 16'sd6);
        run_burst("gaps_stall", 1'b1, 1'b1, 5);

        for (int i = 0; i < 255; i++) push(16'sh8000, 16'sh8000);
        run_burst("max_len32", 1'b1, 1'b0, 1);

        push(16'sh8000, 16'sh8000);
        run_burst("minmin32", 1'b1, 1'b0, 0);

        for (int i = 0; i < 4; i++) push(16'sh8000, 16'sh7FFF);
        for (int i = 0; i < 4; i++) push(16'sh8000, 16'sh7FFF);
        run_burst("neg_sat32", 1'b1, 1'b1, 0);

        // Reset in the middle of a burst with one product in flight.
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_len    = CNT_W'(4);
        cmd_satszp = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("midrst_op_ready", op_ready, 1);
        op_valid = 1'b1;
        op_a     = 16'sd5;
        op_b     = 16'sd7;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
`ifdef J_MAC_SEQ_SATFLAG_EN
        m_sticky = 1'b0;
`endif
        push(16'sd3, 16'sd3);
        run_burst("after_rst", 1'b1, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            int len = $urandom_range(0, 10);
            for (int i = 0; i < len; i++) push(rnd16(), rnd16());
            run_burst($sformatf("rand%0d", t), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
